approx_mult_seq: RTL and testbench

- Sequential unsigned approximate multiplier.
- Each operand is reduced to its n_effective most-significant bits, starting at its leading one.
- The reduced operands are multiplied by an iterative shift-add datapath, one partial product per clock.
- The product is re-scaled and its upper n_input bits are returned. Used as a low-area multiply unit behind a Start/Done handshake.

---
 rtl/approx_mult_seq.sv | 106 ++++++++++
 tb/tb_approx_mult_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/approx_mult_seq.sv
// approx_mult_seq: sequential leading-one-truncated approximate unsigned multiplier
module approx_mult_seq #(
  parameter int n_input = 16,
  parameter int n_effective = 8,
  parameter int n_multiplications = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic [n_input-1:0] pin1,
  input  logic [n_input-1:0] pin2,
  output logic               Done,
  output logic [n_input-1:0] pout
);
  localparam int SW = $clog2(n_input + 1);
  localparam int CW = (n_multiplications > 1) ? $clog2(n_multiplications) : 1;
  localparam int AW = 2 * n_effective;
  typedef enum logic [2:0] {IDLE, NORM, MULT, FINAL, DONE} state_t;
  state_t                   state_q, state_d;
  logic [n_input-1:0]       a_q, a_d, b_q, b_d, pout_q, pout_d;
  logic [n_effective-1:0]   ta_q, ta_d, tb_q, tb_d, tb_sh;
  logic [SW-1:0]            sa_q, sa_d, sb_q, sb_d;
  logic [AW-1:0]            acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2*n_input-1:0]     full;
  logic                     done_q, done_d;
  // Right-shift that leaves the leading one in the top kept bit; zero for small or zero operands.
  function automatic logic [SW-1:0] shift_of(input logic [n_input-1:0] x);
    shift_of = '0;
    for (int k = 0; k < n_input; k++)
      if (x[k]) shift_of = (k + 1 > n_effective) ? SW'(k + 1 - n_effective) : '0;
  endfunction
  assign Done = done_q;
  assign pout = pout_q;
  // Next-state and datapath: normalise, shift-add one multiplier bit per cycle, rescale.
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    ta_d = ta_q;
    tb_d = tb_q;
    sa_d = sa_q;
    sb_d = sb_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    pout_d = pout_q;
    done_d = 1'b0;
    tb_sh = tb_q >> cnt_q;
    full = (2 * n_input)'(acc_q) << ({1'b0, sa_q} + {1'b0, sb_q});
    case (state_q)
      IDLE: if (Start) begin
        a_d = pin1;
        b_d = pin2;
        state_d = NORM;
      end
      NORM: begin
        sa_d = shift_of(a_q);
        sb_d = shift_of(b_q);
        ta_d = n_effective'(a_q >> shift_of(a_q));
        tb_d = n_effective'(b_q >> shift_of(b_q));
        acc_d = '0;
        cnt_d = '0;
        state_d = MULT;
      end
      MULT: begin
        acc_d = acc_q + (tb_sh[0] ? (AW'(ta_q) << cnt_q) : '0);
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(n_multiplications - 1)) ? FINAL : MULT;
      end
      FINAL: begin
        pout_d = full[2*n_input-1:n_input];
        done_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State register with synchronous reset that aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      ta_q <= '0;
      tb_q <= '0;
      sa_q <= '0;
      sb_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      pout_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      ta_q <= ta_d;
      tb_q <= tb_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      pout_q <= pout_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_approx_mult_seq.sv
// tb_approx_mult_seq: scoreboard bench for approx_mult_seq with directed vectors
module tb_approx_mult_seq;
  logic clk = 1'b0, rst = 1'b1, Start = 1'b0, Done;
  logic [15:0] pin1 = '0, pin2 = '0, pout;
  typedef struct {logic [15:0] exp; int due;} exp_t;
  exp_t sb[$];
  int nc = 0, n_cmp = 0, n_err = 0;
  logic [15:0] va[13] = '{16'hD551, 16'h0100, 16'h0100, 16'h0200, 16'h0400, 16'h0400, 16'h0800,
                          16'h0800, 16'h0800, 16'h1000, 16'h8000, 16'h0000, 16'h0003};
  logic [15:0] vb[13] = '{16'hFFFF, 16'h0100, 16'h0200, 16'h0200, 16'h0200, 16'h0400, 16'h0400,
                          16'h0800, 16'h1000, 16'h1000, 16'h8000, 16'hFFFF, 16'h0005};
  logic [15:0] ve[13] = '{16'hD42B, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020,
                          16'h0040, 16'h0080, 16'h0100, 16'h4000, 16'h0000, 16'h0000};
  approx_mult_seq dut (.clk(clk), .rst(rst), .Start(Start), .pin1(pin1), .pin2(pin2),
                       .Done(Done), .pout(pout));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  // Monitor: every Done pulse must match the oldest expectation in value and timing.
  always @(negedge clk) begin
    exp_t e;
    nc++;
    if (Done === 1'b1) begin
      if (sb.size() == 0) check("spurious_done", 32'(nc), 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        check("pout", 32'(pout), 32'(e.exp));
        check("latency", 32'(nc), 32'(e.due));
      end
    end
  end
  task automatic go(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
    @(negedge clk);
    pin1 = a;
    pin2 = b;
    Start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{e, nc + 11});
    Start = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_pout", 32'(pout), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    go(va[0], vb[0], ve[0]);
    repeat (5) @(negedge clk);
    check("pout_before_done", 32'(pout), 32'd0);
    wait_idle();
    for (int i = 1; i < 13; i++) begin
      go(va[i], vb[i], ve[i]);
      wait_idle();
    end
    go(16'hFFFF, 16'hFFFF, 16'hFE01);
    wait_idle();
    check("pout_hold", 32'(pout), 32'h0000_FE01);
    go(16'hD551, 16'hFFFF, 16'hD42B);
    repeat (3) @(negedge clk);
    pin1 = 16'h0100;
    pin2 = 16'h0100;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_idle();
    @(negedge clk);
    pin1 = 16'hFFFF;
    pin2 = 16'hFFFF;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_pout", 32'(pout), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    repeat (15) @(negedge clk);
    go(16'h0800, 16'h1000, 16'h0080);
    wait_idle();
    @(negedge clk);
    pin1 = 16'h0400;
    pin2 = 16'h0200;
    Start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{16'h0008, nc + 11});
    sb.push_back('{16'h0008, nc + 23});
    repeat (20) @(negedge clk);
    Start = 1'b0;
    wait_idle();
    repeat (15) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
